pp_pipeline_accel_udiv_issue_ctrl: RTL
======================================

PP_PIPELINE_ACCEL_UDIV_ISSUE_CTRL -- requirements
Module: pp_pipeline_accel_udiv_issue_ctrl

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  DIVIDEND_W  64  dividend width
  DIVISOR_W   16  divisor width
  TAG_W       4   request tag width
  LAT_MAX     80  cycles allowed from div_start to div_done before timeout
  OUT_DEPTH   2   result FIFO entries (power of 2, >=2)
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
  clk         in   1            clock
  reset       in   1            synchronous active-high reset
  in_valid    in   1            request valid
  in_ready    out  1            request accepted when in_valid&in_ready
  in_dividend in   DIVIDEND_W   unsigned dividend
  in_divisor  in   DIVISOR_W    unsigned divisor
  in_tag      in   TAG_W        opaque tag returned with the result
  div_ce      out  1            clock enable to the sequential divider
  div_start   out  1            one-cycle start pulse to the divider
  div_din0    out  DIVIDEND_W   dividend to the divider
  div_din1    out  DIVISOR_W    divisor to the divider
  div_done    in   1            divider completion pulse
  div_dout    in   DIVIDEND_W   divider quotient, valid with and after div_done
  out_valid   out  1            result valid
  out_ready   in   1            result consumed when out_valid&out_ready
  out_quot    out  DIVIDEND_W   quotient
  out_tag     out  TAG_W        tag of the request
  out_dz      out  1            divisor was zero
  out_tmo     out  1            divider timed out
REQ-003 SHALL use one clock, clk; reset is synchronous and active-high.

Function
REQ-004 SHALL implement FSM states IDLE, ISSUE, WAIT, CAPT; one request in flight at a time.
REQ-005 in_ready SHALL be 1 only in IDLE with result FIFO not full.
REQ-006 On accept with in_divisor!=0: latch dividend/divisor/tag, go ISSUE.
REQ-007 On accept with in_divisor==0: issue no div_start; push {quot=all-ones, tag, dz=1, tmo=0} into FIFO on the next edge; stay IDLE.
REQ-008 ISSUE SHALL last one cycle with div_start=1, div_din0/div_din1 driven from latched operands; then go WAIT.
REQ-009 div_din0/div_din1 SHALL stay stable from ISSUE until leaving WAIT.
REQ-010 div_ce SHALL be 1 in every cycle after reset deasserts; 0 during reset.
REQ-011 WAIT SHALL count cycles from 1; div_done seen -> CAPT.
REQ-012 CAPT SHALL push {div_dout, tag, dz=0, tmo=0} in one cycle, then go IDLE.
REQ-013 If count reaches LAT_MAX without div_done: push {quot=0, tag, dz=0, tmo=1}, go IDLE; subsequent stray div_done outside WAIT SHALL be ignored.
REQ-014 div_done in the same cycle the count reaches LAT_MAX SHALL count as completion (CAPT path), not timeout.
REQ-015 Result FIFO: OUT_DEPTH entries, first-word-fall-through; out_* driven from head; simultaneous push and pop on a full FIFO SHALL NOT occur because accept requires not-full.
REQ-016 Entry to ISSUE SHALL require FIFO not full at accept time, so CAPT/timeout push never overflows (in-flight request reserves a slot: full = occupancy + inflight == OUT_DEPTH).
REQ-017 Results SHALL leave in acceptance order; latency accept->out_valid for nonzero divisor = 1 (ISSUE) + divider latency + 1 (CAPT) + 1.

Reset
REQ-018 Reset SHALL force: state IDLE, FIFO empty, counter 0, in_ready 0 during reset then 1, div_start 0, div_ce 0, out_valid 0, out_quot/out_tag/out_dz/out_tmo 0.
REQ-019 Reset mid-operation SHALL discard the in-flight request and all FIFO entries; no result produced for them.

Structure
REQ-020 Shared package SHALL hold the FSM state enum, the result-entry struct {quot, tag, dz, tmo}, and the all-ones dz constant.
REQ-021 Result FIFO SHALL be one sub-module, pp_pipeline_accel_udiv_res_fifo; divider is external.

Verification
REQ-022 1000/7, tag 3, out_ready=1, divider model latency 68 -> out_quot=142, tag 3, dz=0, tmo=0; exactly one div_start pulse.
REQ-023 5/0, tag 9 -> out_quot=all-ones, dz=1 one cycle after accept; div_start never asserted.
REQ-024 out_ready=0, send 100/10 then 81/9 then 7/1 -> first two accepted, in_ready=0 for third until one pop; results 10, 9, 7 in order.
REQ-025 Divider model never asserts div_done -> after 80 WAIT cycles out_tmo=1, out_quot=0; late div_done ignored, next request 64/8 returns 8.
REQ-026 reset pulsed 20 cycles into WAIT -> out_valid=0, FIFO empty, next 9/3 returns 3 with correct tag.

Source files
------------

// File: rtl/pp_pipeline_accel_udiv_issue_ctrl_pkg.sv
// Shared types for the unsigned-divide issue controller: FSM states, result entry
// layout and the quotient reported for a zero divisor.
package pp_pipeline_accel_udiv_issue_ctrl_pkg;

  localparam int DIVIDEND_W_D = 64;
  localparam int DIVISOR_W_D  = 16;
  localparam int TAG_W_D      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_CAPT  = 2'd3
  } state_t;

  // Packed so that {quot, tag, dz, tmo} is the exact bit layout held in the result FIFO.
  typedef struct packed {
    logic [DIVIDEND_W_D-1:0] quot;
    logic [TAG_W_D-1:0]      tag;
    logic                    dz;
    logic                    tmo;
  } res_t;

  localparam logic [DIVIDEND_W_D-1:0] DZ_QUOT = '1;

endpackage

// File: rtl/pp_pipeline_accel_udiv_issue_ctrl_if.sv
// Request, divider and result signal bundle for the divide issue controller.
// Handshake rule for both in_* and out_*: a transfer happens on a rising clk edge
// where valid and ready are both 1; valid may rise without waiting for ready.
interface pp_pipeline_accel_udiv_issue_ctrl_if #(
  parameter int DIVIDEND_W = 64,
  parameter int DIVISOR_W  = 16,
  parameter int TAG_W      = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] in_dividend;
  logic [DIVISOR_W-1:0]  in_divisor;
  logic [TAG_W-1:0]      in_tag;
  logic                  div_ce;
  logic                  div_start;
  logic [DIVIDEND_W-1:0] div_din0;
  logic [DIVISOR_W-1:0]  div_din1;
  logic                  div_done;
  logic [DIVIDEND_W-1:0] div_dout;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVIDEND_W-1:0] out_quot;
  logic [TAG_W-1:0]      out_tag;
  logic                  out_dz;
  logic                  out_tmo;

  modport slave (
    input  in_valid, in_dividend, in_divisor, in_tag, div_done, div_dout, out_ready,
    output in_ready, div_ce, div_start, div_din0, div_din1,
           out_valid, out_quot, out_tag, out_dz, out_tmo
  );

  modport master (
    output in_valid, in_dividend, in_divisor, in_tag, div_done, div_dout, out_ready,
    input  in_ready, div_ce, div_start, div_din0, div_din1,
           out_valid, out_quot, out_tag, out_dz, out_tmo
  );
endinterface

// File: rtl/pp_pipeline_accel_udiv_res_fifo.sv
// First-word-fall-through result FIFO; head reads as zero while empty so the
// result outputs are quiet after reset.
module pp_pipeline_accel_udiv_res_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 70
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic                   head_valid,
  output logic [W-1:0]           head_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt_q;
  logic          pop_ok;

  assign pop_ok     = pop && (cnt_q != '0);
  assign head_valid = (cnt_q != '0);
  assign head_data  = head_valid ? mem[rd_ptr] : '0;
  assign count      = cnt_q;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      cnt_q <= cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop_ok};
    end
  end
endmodule

// File: rtl/pp_pipeline_accel_udiv_issue_ctrl.sv
// Issues one request at a time to an external sequential divider, bounds its latency
// with a timeout, and queues {quot, tag, dz, tmo} results in acceptance order.
module pp_pipeline_accel_udiv_issue_ctrl
  import pp_pipeline_accel_udiv_issue_ctrl_pkg::*;
#(
  parameter int DIVIDEND_W = 64,
  parameter int DIVISOR_W  = 16,
  parameter int TAG_W      = 4,
  parameter int LAT_MAX    = 80,
  parameter int OUT_DEPTH  = 2
) (
  input  logic   clk,
  input  logic   reset,
  pp_pipeline_accel_udiv_issue_ctrl_if.slave bus,
  output state_t dbg_state
);
  localparam int CNT_W = $clog2(LAT_MAX + 1);
  localparam int RES_W = DIVIDEND_W + TAG_W + 2;
  localparam int OCC_W = $clog2(OUT_DEPTH) + 1;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [DIVIDEND_W-1:0] op_a;
  logic [DIVISOR_W-1:0]  op_b;
  logic [TAG_W-1:0]      op_tag;
  logic [OCC_W-1:0]      occ;
  logic [OCC_W:0]        slots_used;
  logic                  accept;
  logic                  push;
  logic [RES_W-1:0]      push_data;
  logic [RES_W-1:0]      head;
  logic                  fifo_valid;

  // A request past IDLE holds a FIFO slot so its eventual push can never overflow.
  assign slots_used   = {1'b0, occ} + {{OCC_W{1'b0}}, (state != ST_IDLE)};
  assign bus.in_ready = !reset && (state == ST_IDLE) && (slots_used < (OCC_W+1)'(OUT_DEPTH));
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.div_ce    = !reset;
  assign bus.div_start = (state == ST_ISSUE);
  assign bus.div_din0  = op_a;
  assign bus.div_din1  = op_b;
  assign dbg_state     = state;

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_data = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (bus.in_divisor != '0) begin
            state_nxt = ST_ISSUE;
          end else begin
            push      = 1'b1;
            push_data = {{DIVIDEND_W{1'b1}}, bus.in_tag, 1'b1, 1'b0};
          end
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        // A completion on the final allowed cycle still wins over the timeout.
        if (bus.div_done) begin
          state_nxt = ST_CAPT;
        end else if (cnt == CNT_W'(LAT_MAX)) begin
          push      = 1'b1;
          push_data = {{DIVIDEND_W{1'b0}}, op_tag, 1'b0, 1'b1};
          state_nxt = ST_IDLE;
        end
      end
      ST_CAPT: begin
        push      = 1'b1;
        push_data = {bus.div_dout, op_tag, 1'b0, 1'b0};
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_tag <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == ST_WAIT) cnt <= (state == ST_WAIT) ? cnt + CNT_W'(1) : CNT_W'(1);
      else                      cnt <= '0;
      if ((state == ST_IDLE) && accept && (bus.in_divisor != '0)) begin
        op_a   <= bus.in_dividend;
        op_b   <= bus.in_divisor;
        op_tag <= bus.in_tag;
      end
    end
  end

  pp_pipeline_accel_udiv_res_fifo #(
    .DEPTH (OUT_DEPTH),
    .W     (RES_W)
  ) u_res_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (push_data),
    .pop        (bus.out_valid && bus.out_ready),
    .head_valid (fifo_valid),
    .head_data  (head),
    .count      (occ)
  );

  assign bus.out_valid = fifo_valid;
  assign {bus.out_quot, bus.out_tag, bus.out_dz, bus.out_tmo} = head;
endmodule
